junction_scheduler: RTL and testbench

JUNCTION_SCHEDULER -- requirements
Module: junction_scheduler

---
 rtl/junction_pkg.sv | 31 +++
 rtl/rr_pick.sv | 25 ++
 rtl/junction_scheduler.sv | 135 +++++++++++++
 tb/tb_junction_scheduler.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/junction_pkg.sv
// Shared encodings, widths and default timing for the junction scheduler.
package junction_pkg;

    localparam int unsigned NUM_ROADS = 3;
    localparam int unsigned ROAD_W    = 2;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned STATE_W   = 3;

    localparam int unsigned DEF_MIN_GREEN = 4;
    localparam int unsigned DEF_MAX_GREEN = 12;
    localparam int unsigned DEF_YELLOW_T  = 2;
    localparam int unsigned DEF_ALLRED_T  = 1;
    localparam int unsigned DEF_WALK_T    = 6;

    typedef enum logic [STATE_W-1:0] {
        S_ALLRED = 3'd0,
        S_GREEN  = 3'd1,
        S_YELLOW = 3'd2,
        S_WALK   = 3'd3
    } state_e;

    function automatic logic [NUM_ROADS-1:0] road_onehot(input logic [ROAD_W-1:0] road);
        logic [NUM_ROADS-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < NUM_ROADS; i++) begin
            mask[i] = (road == ROAD_W'(i));
        end
        return mask;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request after 'last', wrapping.
module rr_pick
    import junction_pkg::*;
(
    input  logic [NUM_ROADS-1:0] req,
    input  logic [ROAD_W-1:0]    last,
    output logic [ROAD_W-1:0]    idx,
    output logic                 valid
);

    always_comb begin
        logic [ROAD_W-1:0] cand;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= NUM_ROADS; k++) begin
            cand = ROAD_W'((32'(last) + k) % NUM_ROADS);
            if (!valid && req[cand]) begin
                idx   = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/junction_scheduler.sv
// Three-road traffic junction scheduler with min/max green, yellow, all-red
// clearance and a pedestrian walk phase; all outputs are registered.
module junction_scheduler
    import junction_pkg::*;
#(
    parameter int unsigned MIN_GREEN = DEF_MIN_GREEN,
    parameter int unsigned MAX_GREEN = DEF_MAX_GREEN,
    parameter int unsigned YELLOW_T  = DEF_YELLOW_T,
    parameter int unsigned ALLRED_T  = DEF_ALLRED_T,
    parameter int unsigned WALK_T    = DEF_WALK_T
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_ROADS-1:0] req,
    input  logic                 ped_req,
    output logic [NUM_ROADS-1:0] grant,
    output logic [NUM_ROADS-1:0] yellow,
    output logic                 walk,
    output logic [STATE_W-1:0]   state,
    output logic [CNT_W-1:0]     phase_cnt
);

    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] GMIN_LAST   = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST   = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_T - 1);

    logic [STATE_W-1:0]   state_q, state_d;
    logic [CNT_W-1:0]     phase_cnt_q, phase_cnt_d;
    logic [ROAD_W-1:0]    cur_road_q, cur_road_d;
    logic [ROAD_W-1:0]    last_road_q, last_road_d;
    logic                 ped_pending_q, ped_pending_d;
    logic [NUM_ROADS-1:0] grant_q, grant_d;
    logic [NUM_ROADS-1:0] yellow_q, yellow_d;
    logic                 walk_q, walk_d;

    logic [ROAD_W-1:0]    pick_idx;
    logic                 pick_valid;
    logic [NUM_ROADS-1:0] cur_mask;
    logic                 release_green;

    rr_pick u_rr_pick (
        .req   (req),
        .last  (last_road_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Green may end early once the minimum dwell is served and someone else wants the junction.
    assign cur_mask      = road_onehot(cur_road_q);
    assign release_green = !req[cur_road_q] || ((req & ~cur_mask) != '0) || ped_pending_q;

    always_comb begin
        state_d       = state_q;
        cur_road_d    = cur_road_q;
        last_road_d   = last_road_q;
        phase_cnt_d   = phase_cnt_q;
        ped_pending_d = ped_pending_q;
        grant_d       = '0;
        yellow_d      = '0;
        walk_d        = 1'b0;

        case (state_q)
            S_ALLRED: begin
                if (phase_cnt_q >= ALLRED_LAST) begin
                    if (ped_pending_q) begin
                        state_d = S_WALK;
                    end else if (pick_valid) begin
                        state_d     = S_GREEN;
                        cur_road_d  = pick_idx;
                        last_road_d = pick_idx;
                    end
                end
            end
            S_GREEN: begin
                if (phase_cnt_q == GMAX_LAST) begin
                    state_d = S_YELLOW;
                end else if (phase_cnt_q >= GMIN_LAST && release_green) begin
                    state_d = S_YELLOW;
                end
            end
            S_YELLOW: begin
                if (phase_cnt_q == YELLOW_LAST) state_d = S_ALLRED;
            end
            S_WALK: begin
                if (phase_cnt_q == WALK_LAST) state_d = S_ALLRED;
            end
            default: state_d = S_ALLRED;
        endcase

        if (state_d != state_q) begin
            phase_cnt_d = '0;
        end else if (phase_cnt_q != '1) begin
            phase_cnt_d = CNT_W'(phase_cnt_q + 1'b1);
        end

        // A new press on the walk-entry cycle must not be lost.
        if (state_d == S_WALK && state_q != S_WALK) ped_pending_d = 1'b0;
        if (ped_req) ped_pending_d = 1'b1;

        if (state_d == S_GREEN)  grant_d  = road_onehot(cur_road_d);
        if (state_d == S_YELLOW) yellow_d = road_onehot(cur_road_d);
        walk_d = (state_d == S_WALK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_ALLRED;
            phase_cnt_q   <= '0;
            cur_road_q    <= '0;
            last_road_q   <= ROAD_W'(NUM_ROADS - 1);
            ped_pending_q <= 1'b0;
            grant_q       <= '0;
            yellow_q      <= '0;
            walk_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_cnt_q   <= phase_cnt_d;
            cur_road_q    <= cur_road_d;
            last_road_q   <= last_road_d;
            ped_pending_q <= ped_pending_d;
            grant_q       <= grant_d;
            yellow_q      <= yellow_d;
            walk_q        <= walk_d;
        end
    end

    assign grant     = grant_q;
    assign yellow    = yellow_q;
    assign walk      = walk_q;
    assign state     = state_q;
    assign phase_cnt = phase_cnt_q;

endmodule

// File: tb/tb_junction_scheduler.sv
// Directed bench for junction_scheduler: cycle-by-cycle phase sequences with hand-derived expectations.
module tb_junction_scheduler;
    import junction_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic       ped_req;
    logic [2:0] grant;
    logic [2:0] yellow;
    logic       walk;
    logic [2:0] state;
    logic [3:0] phase_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    junction_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .ped_req   (ped_req),
        .grant     (grant),
        .yellow    (yellow),
        .walk      (walk),
        .state     (state),
        .phase_cnt (phase_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_excl(input string tag);
        int nz;
        int ok;
        nz = int'(grant != 3'b000) + int'(yellow != 3'b000) + int'(walk);
        ok = int'($onehot0(grant) && $onehot0(yellow) && nz <= 1);
        check_eq({tag, ".excl"}, 16'(ok), 16'd1);
    endtask

    // Check n consecutive cycles of one phase, {state,grant,yellow,walk} plus phase_cnt from p0.
    task automatic expect_run(input string tag, input logic [2:0] st, input logic [2:0] g,
                              input logic [2:0] y, input logic w, input int p0, input int n);
        int pc;
        for (int i = 0; i < n; i++) begin
            pc = (p0 + i > 15) ? 15 : p0 + i;
            check_eq($sformatf("%s[%0d].out", tag, i), 16'({state, grant, yellow, walk}),
                     16'({st, g, y, w}));
            check_eq($sformatf("%s[%0d].cnt", tag, i), 16'(phase_cnt), 16'(pc));
            check_excl(tag);
            tick();
        end
    endtask

    task automatic do_reset(input logic [2:0] r);
        rst     = 1'b1;
        req     = r;
        ped_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        req     = 3'b000;
        ped_req = 1'b0;

        // Idle after reset: stays all-red, counter saturates
        do_reset(3'b000);
        expect_run("idle", S_ALLRED, 3'b000, 3'b000, 1'b0, 0, 20);

        // Sole demand on road 0: green runs to MAX_GREEN
        do_reset(3'b001);
        expect_run("ext.ar",  S_ALLRED, 3'b000, 3'b000, 1'b0, 0, 1);
        expect_run("ext.g",   S_GREEN,  3'b001, 3'b000, 1'b0, 0, 12);
        expect_run("ext.y",   S_YELLOW, 3'b000, 3'b001, 1'b0, 0, 2);
        expect_run("ext.ar2", S_ALLRED, 3'b000, 3'b000, 1'b0, 0, 1);
        expect_run("ext.g2",  S_GREEN,  3'b001, 3'b000, 1'b0, 0, 1);

        // Competing demand: roads 0 and 1 alternate at MIN_GREEN
        do_reset(3'b011);
        expect_run("cmp.ar",  S_ALLRED, 3'b000, 3'b000, 1'b0, 0, 1);
        expect_run("cmp.g0",  S_GREEN,  3'b001, 3'b000, 1'b0, 0, 4);
        expect_run("cmp.y0",  S_YELLOW, 3'b000, 3'b001, 1'b0, 0, 2);
        expect_run("cmp.ar1", S_ALLRED, 3'b000, 3'b000, 1'b0, 0, 1);
        expect_run("cmp.g1",  S_GREEN,  3'b010, 3'b000, 1'b0, 0, 4);
        expect_run("cmp.y1",  S_YELLOW, 3'b000, 3'b010, 1'b0, 0, 2);
        expect_run("cmp.ar2", S_ALLRED, 3'b000, 3'b000, 1'b0, 0, 1);
        expect_run("cmp.g0b", S_GREEN,  3'b001, 3'b000, 1'b0, 0, 1);

        // Early release: request drops at green cycle 2, green still lasts MIN_GREEN
        do_reset(3'b001);
        expect_run("rel.ar",  S_ALLRED, 3'b000, 3'b000, 1'b0, 0, 1);
        expect_run("rel.ga",  S_GREEN,  3'b001, 3'b000, 1'b0, 0, 2);
        req = 3'b000;
        expect_run("rel.gb",  S_GREEN,  3'b001, 3'b000, 1'b0, 2, 2);
        expect_run("rel.y",   S_YELLOW, 3'b000, 3'b001, 1'b0, 0, 2);
        expect_run("rel.ar2", S_ALLRED, 3'b000, 3'b000, 1'b0, 0, 3);

        // Pedestrian pulse during road 2 green, then rotation resumes at road 0
        do_reset(3'b100);
        expect_run("ped.ar",  S_ALLRED, 3'b000, 3'b000, 1'b0, 0, 1);
        expect_run("ped.ga",  S_GREEN,  3'b100, 3'b000, 1'b0, 0, 1);
        ped_req = 1'b1;
        expect_run("ped.gb",  S_GREEN,  3'b100, 3'b000, 1'b0, 1, 1);
        ped_req = 1'b0;
        expect_run("ped.gc",  S_GREEN,  3'b100, 3'b000, 1'b0, 2, 2);
        expect_run("ped.y",   S_YELLOW, 3'b000, 3'b100, 1'b0, 0, 2);
        expect_run("ped.ar1", S_ALLRED, 3'b000, 3'b000, 1'b0, 0, 1);
        req = 3'b101;
        expect_run("ped.w",   S_WALK,   3'b000, 3'b000, 1'b1, 0, 6);
        expect_run("ped.ar2", S_ALLRED, 3'b000, 3'b000, 1'b0, 0, 1);
        expect_run("ped.g0",  S_GREEN,  3'b001, 3'b000, 1'b0, 0, 1);

        // Reset during yellow aborts the phase immediately
        do_reset(3'b011);
        expect_run("mrs.ar",  S_ALLRED, 3'b000, 3'b000, 1'b0, 0, 1);
        expect_run("mrs.g0",  S_GREEN,  3'b001, 3'b000, 1'b0, 0, 4);
        expect_run("mrs.y",   S_YELLOW, 3'b000, 3'b001, 1'b0, 0, 1);
        rst = 1'b1;
        tick();
        expect_run("mrs.rst", S_ALLRED, 3'b000, 3'b000, 1'b0, 0, 1);
        rst = 1'b0;
        expect_run("mrs.ar2", S_ALLRED, 3'b000, 3'b000, 1'b0, 0, 1);
        expect_run("mrs.g0b", S_GREEN,  3'b001, 3'b000, 1'b0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
